forward_write_arbiter: RTL and testbench

FORWARD_WRITE_ARBITER -- requirements
Module: forward_write_arbiter

---
 rtl/xbar_pkg.sv | 21 ++
 rtl/grant_order_fifo.sv | 45 ++++
 rtl/forward_write_arbiter.sv | 96 +++++++++
 tb/tb_forward_write_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar types and index helpers.
// Imported by the write-path arbiter and its order queue.
package xbar_pkg;

  localparam int MASTERS = 2;
  localparam int SLAVES  = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_idx(input int a, input int n);
    return (a >= n) ? a - n : a;
  endfunction

  localparam int MIDX_W = idx_w(MASTERS);
  localparam int SIDX_W = idx_w(SLAVES);

  typedef logic [MIDX_W-1:0] order_entry_t;

endpackage

// File: rtl/grant_order_fifo.sv
// Queue of granted master indices, in AW grant order.
// Extra pointer MSB separates full from empty.
module grant_order_fifo #(
  parameter int depth = 8,
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [width-1:0] mem [depth];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/forward_write_arbiter.sv
// Per-slave AW round-robin arbiter with in-order W forwarding.
// W bursts follow AW grant order; no interleave.
module forward_write_arbiter
  import xbar_pkg::*;
#(
  parameter int masters           = 2,
  parameter int slaves            = 2,
  parameter int i_am_slave_number = 0,
  parameter int pending_depth     = 8
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        master_aw_empty      [masters],
  input  logic [idx_w(slaves)-1:0]    master_aw_dest_slave [masters],
  input  logic                        master_w_empty       [masters],
  input  logic                        master_w_last        [masters],
  input  logic                        slave_aw_fifo_full,
  input  logic                        slave_w_fifo_full,
  output logic                        aw_push,
  output logic [idx_w(masters)-1:0]   aw_grant_master,
  output logic                        aw_full_to_master    [masters],
  output logic                        w_push,
  output logic [idx_w(masters)-1:0]   w_grant_master,
  output logic                        w_full_to_master     [masters],
  output logic                        order_full
);

  localparam int MW = idx_w(masters);
  localparam int SW = idx_w(slaves);

  logic [masters-1:0] req;
  logic [MW-1:0]      rr_ptr;
  logic [MW-1:0]      winner;
  logic               found;
  logic [MW-1:0]      q_head;
  logic               q_full;
  logic               q_empty;
  logic               q_pop;

  always_comb begin
    req = '0;
    for (int m = 0; m < masters; m++)
      req[m] = !master_aw_empty[m] &&
               (master_aw_dest_slave[m] == SW'(i_am_slave_number));
  end

  // First requester at or after rr_ptr, wrapping upward.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    for (int i = 0; i < masters; i++) begin
      if (!found && req[wrap_idx(int'(rr_ptr) + i, masters)]) begin
        winner = MW'(wrap_idx(int'(rr_ptr) + i, masters));
        found  = 1'b1;
      end
    end
  end

  assign aw_grant_master = winner;
  assign aw_push    = ARESETn && found && !slave_aw_fifo_full && !q_full;
  assign order_full = ARESETn && q_full;

  assign w_grant_master = (!ARESETn || q_empty) ? '0 : q_head;
  assign w_push = ARESETn && !q_empty && !master_w_empty[q_head] &&
                  !slave_w_fifo_full;
  assign q_pop  = w_push && master_w_last[q_head];

  always_comb begin
    for (int m = 0; m < masters; m++) begin
      aw_full_to_master[m] = !(aw_push && aw_grant_master == MW'(m));
      w_full_to_master[m]  = !(w_push && w_grant_master == MW'(m));
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn)
      rr_ptr <= '0;
    else if (aw_push)
      rr_ptr <= (winner == MW'(masters - 1)) ? '0 : winner + 1'b1;
  end

  grant_order_fifo #(
    .depth (pending_depth),
    .width (MW)
  ) u_order (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (aw_push),
    .din   (winner),
    .pop   (q_pop),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_forward_write_arbiter.sv
// Directed bench for forward_write_arbiter, 2 masters, slave 0.
// Vector table plus multi-cycle corner sequences.
module tb_forward_write_arbiter;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic       aw_empty [2];
  logic [0:0] aw_dest  [2];
  logic       w_empty  [2];
  logic       w_last   [2];
  logic       saw_full;
  logic       sw_full;
  logic       aw_push;
  logic [0:0] aw_grant;
  logic       aw_full  [2];
  logic       w_push;
  logic [0:0] w_grant;
  logic       w_full   [2];
  logic       order_full;

  int checks   = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  forward_write_arbiter #(
    .masters           (2),
    .slaves            (2),
    .i_am_slave_number (0),
    .pending_depth     (8)
  ) dut (
    .ACLK                 (ACLK),
    .ARESETn              (ARESETn),
    .master_aw_empty      (aw_empty),
    .master_aw_dest_slave (aw_dest),
    .master_w_empty       (w_empty),
    .master_w_last        (w_last),
    .slave_aw_fifo_full   (saw_full),
    .slave_w_fifo_full    (sw_full),
    .aw_push              (aw_push),
    .aw_grant_master      (aw_grant),
    .aw_full_to_master    (aw_full),
    .w_push               (w_push),
    .w_grant_master       (w_grant),
    .w_full_to_master     (w_full),
    .order_full           (order_full)
  );

  typedef struct {
    logic [1:0] awe;
    logic       d0;
    logic       d1;
    logic [1:0] we;
    logic [1:0] wl;
    logic       saf;
    logic       swf;
    logic       ap;
    logic       ag;
    logic [1:0] af;
    logic       wp;
    logic       wg;
    logic [1:0] wf;
    logic       of;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string n, input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", n, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] awe, input logic d0,
                       input logic d1, input logic [1:0] we,
                       input logic [1:0] wl, input logic saf,
                       input logic swf);
    aw_empty[0] = awe[0];
    aw_empty[1] = awe[1];
    aw_dest[0]  = d0;
    aw_dest[1]  = d1;
    w_empty[0]  = we[0];
    w_empty[1]  = we[1];
    w_last[0]   = wl[0];
    w_last[1]   = wl[1];
    saw_full    = saf;
    sw_full     = swf;
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [1:0] afv();
    return {aw_full[1], aw_full[0]};
  endfunction

  function automatic logic [1:0] wfv();
    return {w_full[1], w_full[0]};
  endfunction

  initial begin
    // awe d0 d1 we wl saf swf | ap ag af wp wg wf of
    tbl[0]  = '{2'b00,0,0,2'b11,2'b00,0,0, 1,0,2'b10,0,0,2'b11,0};
    tbl[1]  = '{2'b00,0,0,2'b11,2'b00,0,0, 1,1,2'b01,0,0,2'b11,0};
    tbl[2]  = '{2'b00,0,0,2'b11,2'b00,0,0, 1,0,2'b10,0,0,2'b11,0};
    tbl[3]  = '{2'b00,0,0,2'b11,2'b00,0,0, 1,1,2'b01,0,0,2'b11,0};
    tbl[4]  = '{2'b11,0,0,2'b10,2'b01,0,0, 0,0,2'b11,1,0,2'b10,0};
    tbl[5]  = '{2'b11,0,0,2'b10,2'b01,0,0, 0,0,2'b11,0,1,2'b11,0};
    tbl[6]  = '{2'b11,0,0,2'b00,2'b11,0,0, 0,0,2'b11,1,1,2'b01,0};
    tbl[7]  = '{2'b11,0,0,2'b00,2'b00,0,0, 0,0,2'b11,1,0,2'b10,0};
    tbl[8]  = '{2'b11,0,0,2'b00,2'b01,0,0, 0,0,2'b11,1,0,2'b10,0};
    tbl[9]  = '{2'b11,0,0,2'b00,2'b10,0,0, 0,0,2'b11,1,1,2'b01,0};
    tbl[10] = '{2'b00,1,0,2'b00,2'b11,0,0, 1,1,2'b01,0,0,2'b11,0};
    tbl[11] = '{2'b10,1,0,2'b00,2'b11,0,0, 0,0,2'b11,1,1,2'b01,0};
    tbl[12] = '{2'b11,0,0,2'b00,2'b11,0,0, 0,0,2'b11,0,0,2'b11,0};
    tbl[13] = '{2'b00,0,0,2'b11,2'b00,1,0, 0,0,2'b11,0,0,2'b11,0};

    ARESETn = 1'b0;
    drive(2'b00, 0, 0, 2'b11, 2'b00, 0, 0);
    #1;
    tick();
    tick();
    chk("rst.aw_push", 2'(aw_push), 2'b00);
    chk("rst.w_push", 2'(w_push), 2'b00);
    chk("rst.order_full", 2'(order_full), 2'b00);
    chk("rst.aw_full", afv(), 2'b11);
    chk("rst.w_full", wfv(), 2'b11);
    chk("rst.w_grant", 2'(w_grant), 2'b00);
    ARESETn = 1'b1;

    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].awe, tbl[k].d0, tbl[k].d1, tbl[k].we,
            tbl[k].wl, tbl[k].saf, tbl[k].swf);
      #1;
      chk($sformatf("v%0d.aw_push", k), 2'(aw_push), 2'(tbl[k].ap));
      chk($sformatf("v%0d.aw_grant", k), 2'(aw_grant), 2'(tbl[k].ag));
      chk($sformatf("v%0d.aw_full", k), afv(), tbl[k].af);
      chk($sformatf("v%0d.w_push", k), 2'(w_push), 2'(tbl[k].wp));
      chk($sformatf("v%0d.w_grant", k), 2'(w_grant), 2'(tbl[k].wg));
      chk($sformatf("v%0d.w_full", k), wfv(), tbl[k].wf);
      chk($sformatf("v%0d.order_full", k), 2'(order_full),
          2'(tbl[k].of));
      tick();
    end

    // Single 4-beat burst from master 1
    drive(2'b01, 0, 0, 2'b11, 2'b00, 0, 0);
    #1;
    chk("len3.aw_push", 2'(aw_push), 2'b01);
    chk("len3.aw_grant", 2'(aw_grant), 2'b01);
    chk("len3.no_bypass", 2'(w_push), 2'b00);
    tick();
    for (int b = 0; b < 4; b++) begin
      drive(2'b11, 0, 0, 2'b01, (b == 3) ? 2'b10 : 2'b00, 0, 0);
      #1;
      chk($sformatf("len3.b%0d.w_push", b), 2'(w_push), 2'b01);
      chk($sformatf("len3.b%0d.w_grant", b), 2'(w_grant), 2'b01);
      chk($sformatf("len3.b%0d.w_full", b), wfv(), 2'b01);
      tick();
    end
    drive(2'b11, 0, 0, 2'b01, 2'b10, 0, 0);
    #1;
    chk("len3.drained.w_push", 2'(w_push), 2'b00);
    chk("len3.drained.w_grant", 2'(w_grant), 2'b00);
    tick();

    // Fill the order queue while W is stalled
    for (int k = 0; k < 8; k++) begin
      drive(2'b00, 0, 0, 2'b00, 2'b11, 0, 1);
      #1;
      chk($sformatf("fill%0d.aw_push", k), 2'(aw_push), 2'b01);
      chk($sformatf("fill%0d.aw_grant", k), 2'(aw_grant), 2'(k % 2));
      chk($sformatf("fill%0d.order_full", k), 2'(order_full), 2'b00);
      chk($sformatf("fill%0d.w_push", k), 2'(w_push), 2'b00);
      tick();
    end
    chk("full.order_full", 2'(order_full), 2'b01);
    chk("full.ninth_blocked", 2'(aw_push), 2'b00);
    chk("full.aw_full", afv(), 2'b11);
    tick();
    drive(2'b00, 0, 0, 2'b00, 2'b11, 0, 0);
    #1;
    chk("drain0.order_full", 2'(order_full), 2'b01);
    chk("drain0.push_blocked", 2'(aw_push), 2'b00);
    chk("drain0.w_push", 2'(w_push), 2'b01);
    chk("drain0.w_grant", 2'(w_grant), 2'b00);
    tick();
    for (int k = 1; k < 8; k++) begin
      drive(2'b11, 0, 0, 2'b00, 2'b11, 0, 0);
      #1;
      chk($sformatf("drain%0d.w_push", k), 2'(w_push), 2'b01);
      chk($sformatf("drain%0d.w_grant", k), 2'(w_grant), 2'(k % 2));
      chk($sformatf("drain%0d.order_full", k), 2'(order_full), 2'b00);
      tick();
    end
    chk("drained.w_push", 2'(w_push), 2'b00);

    // M0 then M1 granted; M1 W data ready first must wait
    drive(2'b10, 0, 0, 2'b01, 2'b11, 0, 0);
    #1;
    chk("ord.aw0.aw_push", 2'(aw_push), 2'b01);
    chk("ord.aw0.aw_grant", 2'(aw_grant), 2'b00);
    tick();
    drive(2'b01, 0, 0, 2'b01, 2'b11, 0, 0);
    #1;
    chk("ord.aw1.aw_push", 2'(aw_push), 2'b01);
    chk("ord.aw1.aw_grant", 2'(aw_grant), 2'b01);
    chk("ord.aw1.w_push", 2'(w_push), 2'b00);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 0, 0, 2'b01, 2'b11, 0, 0);
      #1;
      chk($sformatf("ord.wait%0d.w_push", k), 2'(w_push), 2'b00);
      chk($sformatf("ord.wait%0d.w_grant", k), 2'(w_grant), 2'b00);
      tick();
    end
    drive(2'b11, 0, 0, 2'b00, 2'b10, 0, 0);
    #1;
    chk("ord.m0b0.w_push", 2'(w_push), 2'b01);
    chk("ord.m0b0.w_full", wfv(), 2'b10);
    tick();
    drive(2'b11, 0, 0, 2'b00, 2'b11, 0, 0);
    #1;
    chk("ord.m0b1.w_push", 2'(w_push), 2'b01);
    chk("ord.m0b1.w_grant", 2'(w_grant), 2'b00);
    tick();
    #1;
    chk("ord.m1.w_push", 2'(w_push), 2'b01);
    chk("ord.m1.w_grant", 2'(w_grant), 2'b01);
    chk("ord.m1.w_full", wfv(), 2'b01);
    tick();
    chk("ord.done.w_push", 2'(w_push), 2'b00);

    // Reset in the middle of a 4-beat M0 burst; rr_ptr is 0 here
    drive(2'b10, 0, 0, 2'b10, 2'b00, 0, 0);
    #1;
    chk("mid.aw.aw_push", 2'(aw_push), 2'b01);
    chk("mid.aw.aw_grant", 2'(aw_grant), 2'b00);
    tick();
    for (int b = 0; b < 2; b++) begin
      drive(2'b11, 0, 0, 2'b10, 2'b00, 0, 0);
      #1;
      chk($sformatf("mid.b%0d.w_push", b), 2'(w_push), 2'b01);
      tick();
    end
    ARESETn = 1'b0;
    drive(2'b00, 0, 0, 2'b10, 2'b00, 0, 0);
    #1;
    chk("mid.rst.aw_push", 2'(aw_push), 2'b00);
    chk("mid.rst.w_push", 2'(w_push), 2'b00);
    chk("mid.rst.w_grant", 2'(w_grant), 2'b00);
    chk("mid.rst.aw_full", afv(), 2'b11);
    chk("mid.rst.w_full", wfv(), 2'b11);
    tick();
    ARESETn = 1'b1;
    #1;
    chk("mid.after.w_push", 2'(w_push), 2'b00);
    chk("mid.after.aw_push", 2'(aw_push), 2'b01);
    chk("mid.after.aw_grant", 2'(aw_grant), 2'b00);
    chk("mid.after.order_full", 2'(order_full), 2'b00);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
